// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-8 decoder: walks digits 0..7 over iMask, DIV on / BLANK off.
// Ports: iClk, iRst (sync, high), iRun, iMask[7:0] -> oSel[2:0], oEna[1:0], oTick, oWrap.
module decoder_scan_ctrl #(
  parameter int DIV   = 4,
  parameter int BLANK = 2,
  parameter int CNT_W = 17
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRun,
  input  logic [7:0] iMask,
  output logic [2:0] oSel,
  output logic [1:0] oEna,
  output logic       oTick,
  output logic       oWrap
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_BLANK
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [1:0]       r_ena;
  logic             r_tick;
  logic             r_wrap;

  logic             w_go;
  logic [2:0]       w_from;
  logic [2:0]       w_next;

  // First set bit strictly after cur, searching cyclically.
  function automatic logic [2:0] f_next(
    input logic [7:0] m,
    input logic [2:0] cur
  );
    logic [2:0] idx;
    logic       found;
    f_next = cur;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && m[idx]) begin
        f_next = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign w_go   = iRun && (iMask != 8'h00);
  // Searching after 7 yields the lowest set bit.
  assign w_from = (r_state == ST_IDLE) ? 3'd7 : r_sel;
  assign w_next = f_next(iMask, w_from);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sel   <= 3'd0;
      r_ena   <= 2'b00;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_ena <= 2'b00;
          if (w_go) begin
            r_sel   <= w_next;
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_tick  <= 1'b1;
            r_ena   <= 2'b10;
          end
        end
        ST_SHOW: begin
          if (r_cnt == DIV_LAST) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_ena   <= 2'b00;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLK_LAST) begin
            r_cnt <= '0;
            if (w_go) begin
              r_sel   <= w_next;
              r_state <= ST_SHOW;
              r_tick  <= 1'b1;
              r_wrap  <= (w_next <= r_sel);
              r_ena   <= 2'b10;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_ena   <= 2'b00;
        end
      endcase
    end
  end

  assign oSel  = r_sel;
  assign oEna  = r_ena;
  assign oTick = r_tick;
  assign oWrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomised scoreboard bench for decoder_scan_ctrl.
// Digit-period reference model predicts every cycle; monitor compares at negedge.
module tb_decoder_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int PER   = DIV + BLANK;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] mask;
  logic [2:0] sel;
  logic [1:0] ena;
  logic       tick;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int sel;
    int ena;
    int tick;
    int wrap;
  } exp_t;

  typedef struct {
    int sel;
    int wrap;
  } tick_t;

  exp_t  exp_q[$];
  tick_t tick_q[$];

  decoder_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .CNT_W(17)) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iRun  (run),
    .iMask (mask),
    .oSel  (sel),
    .oEna  (ena),
    .oTick (tick),
    .oWrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nxt(input logic [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) begin
      if (m[(cur + k) % 8]) return (cur + k) % 8;
    end
    return cur;
  endfunction

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", n, cyc, act, req);
    end
  endtask

  // Reference: a digit lives for PER cycles; enabled during its first DIV.
  initial begin : model
    bit   active;
    int   msel;
    int   age;
    exp_t e;
    active = 0;
    msel   = 0;
    age    = 0;
    forever begin
      @(posedge clk);
      cyc++;
      e.tick = 0;
      e.wrap = 0;
      if (rst) begin
        active = 0;
        msel   = 0;
        age    = 0;
      end else if (!active) begin
        if (run && mask != 0) begin
          msel   = nxt(mask, 7);
          active = 1;
          age    = 0;
          e.tick = 1;
        end
      end else if (age == PER - 1) begin
        if (run && mask != 0) begin
          int ns;
          ns     = nxt(mask, msel);
          e.wrap = (ns <= msel) ? 1 : 0;
          msel   = ns;
          age    = 0;
          e.tick = 1;
        end else begin
          active = 0;
        end
      end else begin
        age++;
      end
      e.sel = msel;
      e.ena = (active && age < DIV) ? 2 : 0;
      exp_q.push_back(e);
      if (e.tick == 1) begin
        tick_t t;
        t.sel  = msel;
        t.wrap = e.wrap;
        tick_q.push_back(t);
      end
    end
  end

  initial begin : monitor
    exp_t  e;
    tick_t t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sel", int'(sel), e.sel);
        chk("ena", int'(ena), e.ena);
        chk("tick", int'(tick), e.tick);
        chk("wrap", int'(wrap), e.wrap);
      end
      if (tick === 1'b1) begin
        if (tick_q.size() == 0) begin
          chk("tick_unexpected", 1, 0);
        end else begin
          t = tick_q.pop_front();
          chk("tick_sel", int'(sel), t.sel);
          chk("tick_wrap", int'(wrap), t.wrap);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_digit(input int d, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (sel == 3'(d) && ena == 2'b10) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_digit_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin : stim
    bit ok;
    rst  = 1'b1;
    run  = 1'b1;
    mask = 8'hFF;
    step(3);
    rst = 1'b0;
    step(60);
    mask = 8'b1010_0100;
    step(40);
    mask = 8'b0001_0000;
    step(30);
    mask = 8'hFF;
    do_reset();
    wait_digit(3, ok);
    run = 1'b0;
    step(15);
    run = 1'b1;
    step(20);
    mask = 8'h00;
    do_reset();
    step(30);
    mask = 8'hFF;
    step(20);
    mask = 8'h00;
    step(20);
    mask = 8'b0110_0110;
    step(10);
    wait_digit(5, ok);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(30);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 8'h00;
          1: mask = 8'(1 << $urandom_range(0, 7));
          default: mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 19) == 0) run = ~run;
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst  = 1'b0;
    step(4);
    chk("tick_queue_drained", tick_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
